// File: rtl/addsub_pkg.sv
// Shared encodings for the chunked adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_pkg;

  // Operation codes presented on the op port
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit adder with carry in and carry out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // One extra bit captures the carry out of the chunk
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle ADD/ADC/SUB/SBB over WIDTH bits, CHUNK bits per cycle via one shared chunk adder.
// Latency: out_valid rises NCHUNK cycles after the accepting edge; NCHUNK+2 cycles per op minimum.
// Backpressure: DONE holds result/flags stable until out_ready; in_ready only high in IDLE.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             sign,
  output logic             zero
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int KW     = $clog2(NCHUNK + 1);

  // Reject widths that cannot be split into whole chunks
  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("addsub_seq: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("addsub_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // b already inverted for SUB/SBB
  logic             c_q, c_d;       // running carry between chunks
  logic [KW-1:0]    k_q, k_d;       // chunk index
  logic [WIDTH-1:0] acc_q, acc_d;   // working sum, filled one chunk per cycle
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ov_q, ov_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             chunk_cout;
  logic [WIDTH-1:0] acc_next;

  // Decode the operation into effective B operand and initial carry
  always_comb begin
    b_eff   = b;
    cin_eff = 1'b0;
    case (op)
      OP_ADD: begin
        b_eff   = b;
        cin_eff = 1'b0;
      end
      OP_ADC: cin_eff = carry_in;
      OP_SUB: begin
        b_eff   = ~b;
        cin_eff = 1'b1;
      end
      OP_SBB: begin
        b_eff   = ~b;
        cin_eff = carry_in;
      end
      default: begin
        b_eff   = b;
        cin_eff = 1'b0;
      end
    endcase
  end

  // Select the operand chunks addressed by the chunk index
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  add_chunk #(
    .W(CHUNK)
  ) u_add_chunk (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (c_q),
    .sum (sum_chunk),
    .cout(chunk_cout)
  );

  // Splice the fresh chunk sum into the working accumulator
  always_comb begin
    acc_next = acc_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        acc_next[i*CHUNK +: CHUNK] = sum_chunk;
      end
    end
  end

  // Next-state and datapath control; published result/flags change only on entry to DONE
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ov_d     = ov_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          c_d     = cin_eff;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_next;
        c_d   = chunk_cout;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NCHUNK - 1)) begin
          state_d  = S_DONE;
          result_d = acc_next;
          cout_d   = chunk_cout;
          sign_d   = acc_next[WIDTH-1];
          ov_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
          zero_d   = (acc_next == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ov_q     <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ov_q;
  assign sign      = sign_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: 16-bit/8-bit chunk instance plus a single-chunk instance.
// Latency: checks out_valid arrives exactly NCHUNK cycles after accept.
// Backpressure: holds out_ready low in DONE and checks outputs stay frozen.
module tb_addsub_seq;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        cout;
    logic        ov;
    logic        sgn;
    logic        zro;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, iv16, out_ready;
  logic [1:0]  op_i;
  logic [15:0] a_i, b_i;
  logic        cin_i;

  logic        rdy8, vld8, co8, ov8, sg8, zr8;
  logic [15:0] res8;
  logic        rdy16, vld16, co16, ov16, sg16, zr16;
  logic [15:0] res16;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(16), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .op(op_i),
    .a(a_i), .b(b_i), .carry_in(cin_i), .out_valid(vld8), .out_ready(out_ready),
    .result(res8), .carry_out(co8), .overflow(ov8), .sign(sg8), .zero(zr8)
  );

  addsub_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .op(op_i),
    .a(a_i), .b(b_i), .carry_in(cin_i), .out_valid(vld16), .out_ready(out_ready),
    .result(res16), .carry_out(co16), .overflow(ov16), .sign(sg16), .zero(zr16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Run one vector on the selected instance, holding out_ready low for 'hold' cycles in DONE
  task automatic run_vec(input bit use16, input vec_t v, input int hold, input string tag);
    int lat;
    int exp_lat;
    exp_lat = use16 ? 1 : 2;
    @(negedge clk);
    op_i  = v.op;
    a_i   = v.a;
    b_i   = v.b;
    cin_i = v.cin;
    if (use16) iv16 = 1'b1; else iv8 = 1'b1;
    chk({tag, ".in_ready_idle"}, use16 ? rdy16 : rdy8, 1);
    @(posedge clk);
    #1;
    iv8  = 1'b0;
    iv16 = 1'b0;
    // Scramble operands after acceptance; the result must not depend on them
    a_i   = 16'($urandom);
    b_i   = 16'($urandom);
    op_i  = 2'($urandom);
    cin_i = 1'($urandom);
    @(negedge clk);
    chk({tag, ".busy_in_ready"}, use16 ? rdy16 : rdy8, 0);
    lat = 0;
    while (!(use16 ? vld16 : vld8) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, lat, exp_lat);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, ".out_valid"}, use16 ? vld16 : vld8, 1);
      chk({tag, ".result"}, use16 ? res16 : res8, v.res);
      chk({tag, ".carry_out"}, use16 ? co16 : co8, v.cout);
      chk({tag, ".overflow"}, use16 ? ov16 : ov8, v.ov);
      chk({tag, ".sign"}, use16 ? sg16 : sg8, v.sgn);
      chk({tag, ".zero"}, use16 ? zr16 : zr8, v.zro);
    end
    out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready_at_handshake"}, use16 ? rdy16 : rdy8, 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".in_ready_after"}, use16 ? rdy16 : rdy8, 1);
    chk({tag, ".out_valid_after"}, use16 ? vld16 : vld8, 0);
    chk({tag, ".result_kept_idle"}, use16 ? res16 : res8, v.res);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     a        b        cin   res      co    ov    sg    zr
    vecs[0] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{2'b10, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'b10, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2'b01, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 16'h0100, 16'h0001, 1'b0, 16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{2'b11, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{2'b01, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; iv8 = 1'b0; iv16 = 1'b0; out_ready = 1'b0;
    op_i = 2'b00; a_i = '0; b_i = '0; cin_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.in_ready", rdy8, 1);
    chk("reset.out_valid", vld8, 0);
    chk("reset.result", res8, 0);
    chk("reset.flags", {co8, ov8, sg8, zr8}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(1'b0, vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE for 5 extra cycles with outputs frozen
    run_vec(1'b0, vecs[6], 5, "backpressure");

    // Single-chunk instance: latency of one cycle
    run_vec(1'b1, vecs[0], 0, "chunk16_ovf");
    run_vec(1'b1, vecs[2], 0, "chunk16_sub");

    // Reset in the middle of CALC discards the operation and clears outputs at once
    @(negedge clk);
    op_i = 2'b00; a_i = 16'h1111; b_i = 16'h2222; cin_i = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    rst = 1'b1;
    #1;
    chk("midcalc_rst.out_valid", vld8, 0);
    chk("midcalc_rst.in_ready", rdy8, 1);
    chk("midcalc_rst.result", res8, 0);
    chk("midcalc_rst.flags", {co8, ov8, sg8, zr8}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(1'b0, '{2'b00, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0},
            0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
